// File: rtl/seg7_scan_ctrl_if.sv
// Display data and pin bundle between status logic and seg7_scan_ctrl.
// Master drives digit data; slave returns anode/segment drive.
interface seg7_scan_ctrl_if #(
  parameter int NDIG = 8,
  parameter int BRW  = 4
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   blank;
  logic [BRW-1:0]    bright;
  logic [NDIG-1:0]   an;
  logic [7:0]        seg;
  logic [IW-1:0]     digit_idx;
  logic              frame_done;

  modport master (
    output digits, dp, blank, bright,
    input  an, seg, digit_idx, frame_done
  );

  modport slave (
    input  digits, dp, blank, bright,
    output an, seg, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with dead time,
// PWM brightness and frame-coherent shadow capture.
module seg7_scan_ctrl #(
  parameter int NDIG = 8,
  parameter int DIV  = 20000,
  parameter int DEAD = 16,
  parameter int BRW  = 4
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_ctrl_if.slave  bus
);
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW  = $clog2(DIV);
  localparam int ONW = CW + BRW + 1;
  localparam logic [ONW-1:0] SPAN = ONW'(DIV - DEAD);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] digits_s;
  logic [NDIG-1:0]   dp_s;
  logic [NDIG-1:0]   blank_s;
  logic [BRW-1:0]    bright_s;
  logic [NDIG-1:0]   an_q;
  logic [7:0]        seg_q;
  logic [IW-1:0]     idx_q;
  logic              done_q;

  logic              last_slot;
  logic              last_dig;
  logic              frame_end;
  logic [ONW-1:0]    prod;
  logic [ONW-1:0]    on_len;
  logic              lit;
  logic [3:0]        nib;
  logic [NDIG-1:0]   an_sel;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h7F;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign last_slot = (cnt == CW'(DIV - 1));
  assign last_dig  = (idx == IW'(NDIG - 1));
  assign frame_end = last_slot && last_dig;

  // Full-width product so max brightness yields exactly DIV-DEAD.
  assign prod   = SPAN * (ONW'(bright_s) + ONW'(1));
  assign on_len = prod >> BRW;

  assign lit = !blank_s[idx]
            && (ONW'(cnt) >= ONW'(DEAD))
            && (ONW'(cnt) < ONW'(DEAD) + on_len);

  assign nib    = digits_s[{idx, 2'b00} +: 4];
  assign an_sel = ~(NDIG'(1) << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      an_q     <= '1;
      seg_q    <= 8'hFF;
      idx_q    <= '0;
      done_q   <= 1'b0;
      digits_s <= bus.digits;
      dp_s     <= bus.dp;
      blank_s  <= bus.blank;
      bright_s <= bus.bright;
    end else begin
      cnt <= last_slot ? '0 : cnt + CW'(1);
      if (last_slot)
        idx <= last_dig ? '0 : idx + IW'(1);
      if (frame_end) begin
        digits_s <= bus.digits;
        dp_s     <= bus.dp;
        blank_s  <= bus.blank;
        bright_s <= bus.bright;
      end
      an_q   <= lit ? an_sel : '1;
      seg_q  <= lit ? {~dp_s[idx], enc(nib)} : 8'hFF;
      idx_q  <= idx;
      done_q <= frame_end;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at NDIG=4, DIV=20, DEAD=4, BRW=2.
// Vector table plus multi-cycle sequences for scan, shadow and reset.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4;
  localparam int DIV  = 20;
  localparam int DEAD = 4;
  localparam int BRW  = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   s_now;

  seg7_scan_ctrl_if #(.NDIG(NDIG), .BRW(BRW)) bus ();

  seg7_scan_ctrl #(
    .NDIG(NDIG), .DIV(DIV), .DEAD(DEAD), .BRW(BRW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  bright;
    int          idx;
    int          cnt;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (state %0d)",
               name, got, want, s_now);
    end
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] p,
                        input logic [3:0] b, input logic [1:0] br);
    bus.digits = d;
    bus.dp     = p;
    bus.blank  = b;
    bus.bright = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_now = -1;
  endtask

  // s_now = scan state (idx*DIV+cnt) that the outputs currently show.
  task automatic step_to(input int t);
    while (s_now < t) begin
      @(negedge clk);
      s_now++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    s_now = -1;
    rst   = 1'b1;
    set_in(16'h3210, 4'h0, 4'h0, 2'd3);

    vt[0]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 0, 0,  4'hF, 8'hFF};
    vt[1]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 0, 3,  4'hF, 8'hFF};
    vt[2]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 0, 4,  4'hE, 8'hC0};
    vt[3]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 0, 19, 4'hE, 8'hC0};
    vt[4]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 1, 4,  4'hD, 8'hF9};
    vt[5]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 2, 10, 4'hB, 8'hA4};
    vt[6]  = '{16'h3210, 4'h0, 4'h0, 2'd3, 3, 19, 4'h7, 8'hB0};
    vt[7]  = '{16'h3210, 4'h0, 4'h0, 2'd0, 0, 7,  4'hE, 8'hC0};
    vt[8]  = '{16'h3210, 4'h0, 4'h0, 2'd0, 0, 8,  4'hF, 8'hFF};
    vt[9]  = '{16'h3210, 4'h0, 4'h0, 2'd1, 1, 11, 4'hD, 8'hF9};
    vt[10] = '{16'h3210, 4'h0, 4'h0, 2'd1, 1, 12, 4'hF, 8'hFF};
    vt[11] = '{16'h3210, 4'h0, 4'h0, 2'd2, 2, 15, 4'hB, 8'hA4};
    vt[12] = '{16'h3210, 4'h0, 4'h0, 2'd2, 2, 16, 4'hF, 8'hFF};
    vt[13] = '{16'h3210, 4'h0, 4'h4, 2'd3, 2, 10, 4'hF, 8'hFF};
    vt[14] = '{16'h3210, 4'h0, 4'h4, 2'd3, 3, 10, 4'h7, 8'hB0};
    vt[15] = '{16'h3218, 4'h1, 4'h0, 2'd3, 0, 5,  4'hE, 8'h00};
    vt[16] = '{16'hFEDC, 4'h0, 4'h0, 2'd3, 3, 4,  4'h7, 8'h8E};
    vt[17] = '{16'h3210, 4'h0, 4'hF, 2'd3, 1, 8,  4'hF, 8'hFF};

    for (int v = 0; v < 18; v++) begin
      set_in(vt[v].digits, vt[v].dp, vt[v].blank, vt[v].bright);
      do_reset();
      step_to(vt[v].idx * DIV + vt[v].cnt);
      chk($sformatf("vec%0d_an", v), 32'(bus.an), 32'(vt[v].an));
      chk($sformatf("vec%0d_seg", v), 32'(bus.seg), 32'(vt[v].seg));
      chk($sformatf("vec%0d_idx", v), 32'(bus.digit_idx),
          32'(vt[v].idx));
    end

    // Lit length per slot for each brightness, and one-hot anodes.
    for (int b = 0; b < 4; b++) begin
      int lit_cnt[4];
      int bad;
      bad = 0;
      for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
      set_in(16'h3210, 4'h0, 4'h0, 2'(b));
      do_reset();
      for (int t = 0; t < NDIG * DIV; t++) begin
        int d;
        int c;
        logic [3:0] want_an;
        step_to(t);
        d = t / DIV;
        c = t % DIV;
        want_an = 4'hF;
        want_an[d] = 1'b0;
        if (bus.an != 4'hF) begin
          lit_cnt[d]++;
          if (bus.an != want_an) bad++;
          if (c < DEAD) bad++;
        end
      end
      chk($sformatf("b%0d_anode_shape", b), 32'(bad), 32'd0);
      for (int d = 0; d < 4; d++)
        chk($sformatf("b%0d_lit_d%0d", b, d), 32'(lit_cnt[d]),
            32'(4 * (b + 1)));
    end

    // Shadow coherency: change data while digit 1 is scanned.
    set_in(16'h3210, 4'h0, 4'h0, 2'd3);
    do_reset();
    step_to(30);
    bus.digits = 16'hFEDC;
    step_to(50);
    chk("shadow_d2_old", 32'(bus.seg), 32'h0A4);
    step_to(70);
    chk("shadow_d3_old", 32'(bus.seg), 32'h0B0);
    step_to(90);
    chk("shadow_d0_new", 32'(bus.seg), 32'h0C6);
    step_to(110);
    chk("shadow_d1_new", 32'(bus.seg), 32'h0A1);
    step_to(130);
    chk("shadow_d2_new", 32'(bus.seg), 32'h086);
    step_to(150);
    chk("shadow_d3_new", 32'(bus.seg), 32'h08E);

    // frame_done: silent under reset, then one pulse per frame.
    begin
      int bad;
      int pulses;
      bad = 0;
      pulses = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.frame_done !== 1'b0) bad++;
      end
      chk("fd_in_reset", 32'(bad), 32'd0);
      rst = 1'b0;
      s_now = -1;
      bad = 0;
      for (int t = 0; t < 3 * NDIG * DIV; t++) begin
        step_to(t);
        if (bus.frame_done === 1'b1) begin
          pulses++;
          if ((t % (NDIG * DIV)) != NDIG * DIV - 1) bad++;
        end
      end
      chk("fd_pulses", 32'(pulses), 32'd3);
      chk("fd_position", 32'(bad), 32'd0);
    end

    // One-cycle reset in the middle of digit 2.
    set_in(16'h3210, 4'h0, 4'h0, 2'd3);
    do_reset();
    step_to(45);
    chk("mid_pre_an", 32'(bus.an), 32'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 32'(bus.an), 32'hF);
    chk("mid_rst_seg", 32'(bus.seg), 32'hFF);
    chk("mid_rst_idx", 32'(bus.digit_idx), 32'd0);
    chk("mid_rst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    s_now = -1;
    begin
      int bad;
      bad = 0;
      for (int t = 0; t < DEAD; t++) begin
        step_to(t);
        if (bus.an != 4'hF || bus.seg != 8'hFF) bad++;
      end
      chk("mid_dead", 32'(bad), 32'd0);
    end
    step_to(DEAD);
    chk("mid_resume_an", 32'(bus.an), 32'hE);
    chk("mid_resume_seg", 32'(bus.seg), 32'hC0);
    chk("mid_resume_idx", 32'(bus.digit_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller for NDIG common-anode digits. It replaces the fixed 8-digit divider-clocked display with a single-clock-domain design that adds per-digit blanking, per-digit decimal point and PWM brightness. It also adds anti-ghosting dead time and frame-coherent shadow capture of display data. It sits between the camera status/counter logic and the board anode/segment pins.

Parameters:
NDIG, 8, number of digits scanned (>=2)
DIV, 20000, clk cycles per digit slot (>= DEAD+2)
DEAD, 16, blanked cycles at the start of each slot (anti-ghosting)
BRW, 4, brightness control width

Ports:
clk  in  1  system clock
rst  in  1  reset
digits  in  4*NDIG  hex nibble per digit; digit i = digits[4i+3:4i]
dp  in  NDIG  decimal point enable per digit, 1 = lit
blank  in  NDIG  per-digit blank, 1 = digit dark
bright  in  BRW  brightness level; 0 = dimmest, all-ones = full
an  out  NDIG  anode enables, active-low, one-hot-low or all ones
seg  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}
digit_idx  out  max(1,$clog2(NDIG))  digit currently scanned
frame_done  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: cnt=0, idx=0, an all ones, seg=8'hFF, digit_idx=0, frame_done=0. While rst=1, the shadow registers load from the inputs every cycle.
- Slot counter cnt: runs 0..DIV-1 and wraps to 0. At the wrap, idx advances; idx wraps from NDIG-1 to 0.
- Shadow capture: on the edge where cnt==DIV-1 and idx==NDIG-1, the shadows for digits, dp, blank and bright load. Input changes mid-frame are invisible until the next frame boundary. No tearing is allowed.
- ON_LEN = floor((DIV-DEAD)*(bright_s+1) / 2^BRW), using the shadowed bright. Intermediate width is sufficient for (DIV-DEAD)*2^BRW, with no truncation. Maximum bright gives ON_LEN = DIV-DEAD.
- Lit condition: DEAD <= cnt < DEAD+ON_LEN and blank_s[idx]==0.
- All outputs are registered with 1-cycle latency from the (cnt, idx) state.
  - Lit: an = ~(1<<idx) and seg = {~dp_s[idx], enc(nibble)}.
  - Not lit: an = all ones and seg = 8'hFF.
- enc, active-low gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- digit_idx: registered copy of idx, aligned with an and seg.
- frame_done: 1 for exactly one cycle, the cycle after the edge where cnt==DIV-1 and idx==NDIG-1. This is the same edge that loads the shadows.
- Never more than one an bit is low. At every digit change, an is all ones for at least DEAD cycles, including when bright is at maximum.
- Reset mid-slot: on the next edge, all outputs return to reset values and scanning restarts at digit 0, cnt 0. No partial pulses survive.
- blank all ones: an stays all ones and seg stays FF. frame_done still pulses every NDIG*DIV cycles.

Test Plan:
(Bench parameters: NDIG=4, DIV=20, DEAD=4, BRW=2. Time t=1 is the first cycle with rst=0.)
- Basic scan: digits=16'h3210, dp=0, blank=0, bright=3, rst 1->0.
  - an=1110 and seg=C0 for cnt 4..19 of slot 0; FF/1111 during dead cycles.
  - Digits 1, 2, 3 follow with seg=F9, A4, B0.
  - an low is never two bits at once.
- Brightness: bright=0 -> each digit lit exactly 4 cycles per 20-cycle slot (cnt 4..7). bright=1 -> 8 cycles; bright=2 -> 12 cycles.
- Blank and dp:
  - blank=4'b0100 -> an[2] never low; slot 2 shows an=1111, seg=FF.
  - dp=4'b0001, digit0=8 -> seg=00 when digit 0 is lit.
- Shadow coherency:
  - Change digits from 16'h3210 to 16'hFEDC while digit 1 is being scanned.
  - Digits 2 and 3 still show 2 and 3; the next frame shows C, d, E, F (seg C6, A1, 86, 8E).
- frame_done: exactly one pulse per 80 cycles, coinciding with the shadow load; none while rst=1.
- Reset mid-operation: assert rst for 1 cycle during digit 2.
  - The next cycle gives an=1111, seg=FF, digit_idx=0.
  - Scanning resumes from digit 0 with a full DEAD interval first.
